// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode-to-execute register that builds the ALU operands
//
// Define ALU_OPSTAGE_FWD_EN to build the EX/MEM bypass network. Without it,
// operands come straight from the register file and decode stalls on any
// RAW dependency against EX or MEM until the producer has retired.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   dec_*               instruction offered by decode (valid/ready handshake)
//   alu_out             result of the instruction currently held (EX bypass)
//   mem_wr_en/rd/data   MEM/WB writeback (MEM bypass)
//   flush               kill the held instruction and refuse acceptance
//   ex_ready, ex_valid  handshake towards the ALU
//   alu_in1/in2/func    registered ALU operands and function
//   ex_rs2_data         forwarded rs2 value (store data)
//   ex_rd/wr_en/is_load destination, write-enable and load marker
module alu_operand_stage #(
    parameter int DBITS     = 32,
    parameter int FUNC_BITS = 5,
    parameter int RBITS     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [FUNC_BITS-1:0] dec_func,
    input  logic [RBITS-1:0]     dec_rs1,
    input  logic [RBITS-1:0]     dec_rs2,
    input  logic                 dec_use_rs1,
    input  logic                 dec_use_rs2,
    input  logic [DBITS-1:0]     dec_rf1,
    input  logic [DBITS-1:0]     dec_rf2,
    input  logic [DBITS-1:0]     dec_imm,
    input  logic                 dec_use_imm,
    input  logic [RBITS-1:0]     dec_rd,
    input  logic                 dec_wr_en,
    input  logic                 dec_is_load,
    input  logic [DBITS-1:0]     alu_out,
    input  logic                 mem_wr_en,
    input  logic [RBITS-1:0]     mem_rd,
    input  logic [DBITS-1:0]     mem_data,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [DBITS-1:0]     alu_in1,
    output logic [DBITS-1:0]     alu_in2,
    output logic [FUNC_BITS-1:0] alu_func,
    output logic [DBITS-1:0]     ex_rs2_data,
    output logic [RBITS-1:0]     ex_rd,
    output logic                 ex_wr_en,
    output logic                 ex_is_load
);
    logic             adv, hazard, hz_ex, take;
    logic             e1, e2, w1, w2;
    logic [DBITS-1:0] op1, op2;

    // Source matches against the held (EX) producer and the MEM/WB writer
    assign e1 = ex_valid & ex_wr_en & (ex_rd == dec_rs1);
    assign e2 = ex_valid & ex_wr_en & (ex_rd == dec_rs2);
    assign w1 = mem_wr_en & (mem_rd == dec_rs1);
    assign w2 = mem_wr_en & (mem_rd == dec_rs2);

    // A load in EX has no result yet; a used source depending on it must wait
    assign hz_ex = ex_is_load & ((dec_use_rs1 & e1) | (dec_use_rs2 & e2));

`ifdef ALU_OPSTAGE_FWD_EN
    assign hazard = hz_ex;
    assign op1    = (e1 & !ex_is_load) ? alu_out : w1 ? mem_data : dec_rf1;
    assign op2    = (e2 & !ex_is_load) ? alu_out : w2 ? mem_data : dec_rf2;
`else
    logic unused_bypass;
    assign unused_bypass = ^{alu_out, mem_data};
    assign hazard = hz_ex | (dec_use_rs1 & (e1 | w1)) | (dec_use_rs2 & (e2 | w2));
    assign op1    = dec_rf1;
    assign op2    = dec_rf2;
`endif

    assign adv       = !ex_valid | ex_ready;
    assign dec_ready = adv & !hazard & !flush;
    assign take      = dec_valid & dec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_func    <= '0;
            ex_rs2_data <= '0;
            ex_rd       <= '0;
            ex_wr_en    <= 1'b0;
            ex_is_load  <= 1'b0;
        end else begin
            // Flush clears the slot even while downstream is stalled
            if (adv | flush)
                ex_valid <= take;
            if (take) begin
                alu_in1     <= op1;
                alu_in2     <= dec_use_imm ? dec_imm : op2;
                alu_func    <= dec_func;
                ex_rs2_data <= op2;
                ex_rd       <= dec_rd;
                ex_wr_en    <= dec_wr_en;
                ex_is_load  <= dec_is_load;
            end
        end
    end
endmodule
